acc_exec_ctrl: RTL and testbench
================================

# acc_exec_ctrl

Multi-cycle execution controller that owns the accumulator (AC), extend bit (E) and operand register (DR) of the Basic Computer datapath. It sequences the shared combinational ALU to execute one accumulator command at a time. It sits between the instruction decoder, which issues commands over a valid/ready handshake, and the memory port, which supplies operands over a req/ack handshake.

## Interface
- `W`, 4: datapath width in bits; must be at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd` in 3: command code (see Operation).
- `cmd_ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse when AC/E/flags are committed.
- `mem_req` out 1: operand request, high throughout FETCH.
- `mem_ack` in 1: operand valid this cycle.
- `mem_data` in W: operand word.
- `alu_op` out 3: ALU operation select.
- `alu_ac` out W: current AC register value.
- `alu_dr` out W: current DR register value.
- `alu_e` out 1: current E register value.
- `alu_result` in W: ALU result.
- `alu_co` in 1: ALU carry/shift-out.
- `alu_ovf` in 1: ALU add overflow.
- `ac` out W, `e` out 1: architectural AC and E.
- `n_flag`, `z_flag`, `v_flag` out 1 each: status flags (see Configuration).

## Operation
- Command codes:
  - 0 ADD(mem), 1 AND(mem), 2 LDA(mem): these fetch an operand.
  - 3 CMA, 4 CIR, 5 CIL, 6 CLA, 7 CLE: register-only.
- ALU op mapping, driven in EXEC only: ADD→0, AND→1, LDA→2, CMA→3, CIR→4, CIL→5. In every other state, `alu_op` = 0. CLA and CLE do not use the ALU.
- States: IDLE, FETCH, EXEC.
  - IDLE: on `cmd_valid`, latch `cmd`. Memory commands go to FETCH; register commands go to EXEC.
  - FETCH: `mem_req`=1. On `mem_ack`, DR←`mem_data` and go to EXEC. Otherwise stay in FETCH; there is no timeout.
  - EXEC: commit the result (below), pulse `done` next cycle, return to IDLE.
- Commit rules:
  - ADD: AC←`alu_result`, E←`alu_co`.
  - AND, LDA, CMA: AC←`alu_result`; E unchanged.
  - CIR, CIL: AC←`alu_result`, E←`alu_co`.
  - CLA: AC←0. CLE: E←0.
- All arithmetic is modulo 2^W. `alu_co` is the only carry source.
- `cmd_valid` outside IDLE is ignored, not queued. `mem_ack` outside FETCH is ignored.
- Reset, including mid-FETCH or mid-EXEC: state←IDLE; AC, DR, E and flags ←0; `done`=0, `mem_req`=0, `cmd_ready`=1, `alu_op`=0. No partial commit.

## Timing
- Command accepted at edge k when `cmd_valid & cmd_ready`.
- Register command: EXEC in cycle k+1, commit at edge k+2, `done` high during cycle k+2, `cmd_ready` high again in cycle k+2. Throughput is one command per 2 cycles.
- Memory command: FETCH starts in cycle k+1. If `mem_ack` is sampled at edge a, EXEC is cycle a+1, commit is at edge a+2, and `done` is high in cycle a+2. Minimum latency (ack in the first FETCH cycle) is 3 cycles.
- `mem_req`, `done` and `cmd_ready` are decoded from registered state only; none depends combinationally on inputs.
- `ac` and `e` change only at the commit edge.

## Configuration
- `ACC_EXEC_CTRL_FLAGS_EN` defined:
  - Flags are registered at every commit.
  - `z_flag` = ~|(new AC), `n_flag` = new AC[W-1].
  - `v_flag` = `alu_ovf` for ADD; 0 for every other command.
- `ACC_EXEC_CTRL_FLAGS_EN` undefined: the flag registers are absent, the three flag ports remain and are tied to 0.

## Structure
- Shared package `acc_exec_pkg` holds:
  - the command-code enum;
  - the ALU op constants (ADD=0, AND=1, TRANSFER=2, COMP=3, SHR=4, SHL=5);
  - the state enum.
- Sub-module `acc_cmd_decode` (combinational) maps the command to {needs_mem, uses_alu, alu_op, writes_ac, e_src}.
- The FSM and registers stay in the top level.

## Test plan
All scenarios use W=4.
1. Reset asserted → `ac`=0, `e`=0, `cmd_ready`=1, `mem_req`=0, `done`=0, flags 0.
2. LDA with `mem_data`=4'h9 and ack in the first FETCH cycle → `done` 3 cycles after accept, AC=9. Then ADD with `mem_data`=4'h8 → AC=4'h1, E=1, `v_flag`=1, `z_flag`=0.
3. AC=4'b1010, E=1, CIL → AC=4'b0101, E=1. Then CLE followed by CIR → AC=4'b0010, E=1. Each command has a 2-cycle accept-to-`done`.
4. ADD with `mem_ack` delayed 3 cycles → `mem_req` high 4 cycles, `cmd_ready` low throughout, a second `cmd_valid` during FETCH is ignored, exactly one `done`.
5. Reset pulsed mid-FETCH → `mem_req` falls asynchronously, AC/E=0, no `done`. A later ack is ignored.
6. `mem_ack` pulsed in IDLE, then CMA with AC=0 → AC=4'hF, `n_flag`=1, DR unchanged.

Source files
------------

// File: rtl/acc_exec_pkg.sv
// acc_exec_pkg: command codes, ALU op selects, controller states and E-source select
// shared by the accumulator execution controller and its command decoder.
`default_nettype none

package acc_exec_pkg;

    typedef enum logic [2:0] {
        CMD_ADD = 3'd0,
        CMD_AND = 3'd1,
        CMD_LDA = 3'd2,
        CMD_CMA = 3'd3,
        CMD_CIR = 3'd4,
        CMD_CIL = 3'd5,
        CMD_CLA = 3'd6,
        CMD_CLE = 3'd7
    } cmd_e;

    localparam logic [2:0] ALU_ADD      = 3'd0;
    localparam logic [2:0] ALU_AND      = 3'd1;
    localparam logic [2:0] ALU_TRANSFER = 3'd2;
    localparam logic [2:0] ALU_COMP     = 3'd3;
    localparam logic [2:0] ALU_SHR      = 3'd4;
    localparam logic [2:0] ALU_SHL      = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        E_KEEP = 2'd0,
        E_CO   = 2'd1,
        E_ZERO = 2'd2
    } e_src_e;

endpackage

`default_nettype wire

// File: rtl/acc_cmd_decode.sv
// acc_cmd_decode: combinational map from an accumulator command to its
// operand need, ALU use, ALU op select, AC write enable and E source.
`default_nettype none

module acc_cmd_decode
    import acc_exec_pkg::*;
(
    input  cmd_e       cmd,
    output logic       needs_mem,
    output logic       uses_alu,
    output logic [2:0] alu_op,
    output logic       writes_ac,
    output e_src_e     e_src
);

    always_comb begin
        needs_mem = 1'b0;
        uses_alu  = 1'b0;
        alu_op    = ALU_ADD;
        writes_ac = 1'b0;
        e_src     = E_KEEP;
        case (cmd)
            CMD_ADD: begin
                needs_mem = 1'b1; uses_alu = 1'b1; alu_op = ALU_ADD;
                writes_ac = 1'b1; e_src = E_CO;
            end
            CMD_AND: begin
                needs_mem = 1'b1; uses_alu = 1'b1; alu_op = ALU_AND;
                writes_ac = 1'b1;
            end
            CMD_LDA: begin
                needs_mem = 1'b1; uses_alu = 1'b1; alu_op = ALU_TRANSFER;
                writes_ac = 1'b1;
            end
            CMD_CMA: begin
                uses_alu = 1'b1; alu_op = ALU_COMP; writes_ac = 1'b1;
            end
            CMD_CIR: begin
                uses_alu = 1'b1; alu_op = ALU_SHR; writes_ac = 1'b1; e_src = E_CO;
            end
            CMD_CIL: begin
                uses_alu = 1'b1; alu_op = ALU_SHL; writes_ac = 1'b1; e_src = E_CO;
            end
            // CLA writes zero because uses_alu stays low
            CMD_CLA: writes_ac = 1'b1;
            CMD_CLE: e_src = E_ZERO;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/acc_exec_ctrl.sv
// acc_exec_ctrl: IDLE/FETCH/EXEC controller owning AC, E and DR; sequences an external ALU.
// Optional status flags are built when ACC_EXEC_CTRL_FLAGS_EN is defined.
`default_nettype none

module acc_exec_ctrl
    import acc_exec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    input  logic [2:0]   cmd,
    output logic         cmd_ready,
    output logic         done,
    output logic         mem_req,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_data,
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_ac,
    output logic [W-1:0] alu_dr,
    output logic         alu_e,
    input  logic [W-1:0] alu_result,
    input  logic         alu_co,
    input  logic         alu_ovf,
    output logic [W-1:0] ac,
    output logic         e,
    output logic         n_flag,
    output logic         z_flag,
    output logic         v_flag
);

    state_e       r_state;
    state_e       w_next;
    cmd_e         r_cmd;
    logic [W-1:0] r_ac;
    logic [W-1:0] r_dr;
    logic         r_e;
    logic         r_done;

    cmd_e         w_dec_cmd;
    logic         w_needs_mem;
    logic         w_uses_alu;
    logic [2:0]   w_alu_op;
    logic         w_writes_ac;
    e_src_e       w_e_src;
    logic [W-1:0] w_new_ac;
    logic [W-1:0] w_commit_ac;

    // One decoder serves both the IDLE routing decision and the EXEC commit
    assign w_dec_cmd = (r_state == ST_IDLE) ? cmd_e'(cmd) : r_cmd;

    acc_cmd_decode u_decode (
        .cmd       (w_dec_cmd),
        .needs_mem (w_needs_mem),
        .uses_alu  (w_uses_alu),
        .alu_op    (w_alu_op),
        .writes_ac (w_writes_ac),
        .e_src     (w_e_src)
    );

    assign w_new_ac    = w_uses_alu ? alu_result : '0;
    assign w_commit_ac = w_writes_ac ? w_new_ac : r_ac;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid) w_next = w_needs_mem ? ST_FETCH : ST_EXEC;
            ST_FETCH: if (mem_ack) w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_ADD;
            r_ac    <= '0;
            r_dr    <= '0;
            r_e     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_EXEC);
            if (r_state == ST_IDLE && cmd_valid) r_cmd <= cmd_e'(cmd);
            if (r_state == ST_FETCH && mem_ack) r_dr <= mem_data;
            if (r_state == ST_EXEC) begin
                r_ac <= w_commit_ac;
                case (w_e_src)
                    E_CO:    r_e <= alu_co;
                    E_ZERO:  r_e <= 1'b0;
                    default: r_e <= r_e;
                endcase
            end
        end
    end

`ifdef ACC_EXEC_CTRL_FLAGS_EN
    logic r_n;
    logic r_z;
    logic r_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_v <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_n <= w_commit_ac[W-1];
            r_z <= ~|w_commit_ac;
            r_v <= (r_cmd == CMD_ADD) & alu_ovf;
        end
    end

    assign n_flag = r_n;
    assign z_flag = r_z;
    assign v_flag = r_v;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = alu_ovf;
    assign n_flag = 1'b0;
    assign z_flag = 1'b0;
    assign v_flag = 1'b0;
`endif

    assign cmd_ready = (r_state == ST_IDLE);
    assign mem_req   = (r_state == ST_FETCH);
    assign done      = r_done;
    assign alu_op    = (r_state == ST_EXEC) ? w_alu_op : ALU_ADD;
    assign alu_ac    = r_ac;
    assign alu_dr    = r_dr;
    assign alu_e     = r_e;
    assign ac        = r_ac;
    assign e         = r_e;

endmodule

`default_nettype wire

// File: tb/tb_acc_exec_ctrl.sv
// tb_acc_exec_ctrl: directed table-driven bench for acc_exec_ctrl (W=4) with a
// behavioural ALU model and hand-written reset / stray-handshake sequences.
`default_nettype none

module tb_acc_exec_ctrl;

`ifdef ACC_EXEC_CTRL_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       done;
    logic       mem_req;
    logic       mem_ack;
    logic [3:0] mem_data;
    logic [2:0] alu_op;
    logic [3:0] alu_ac;
    logic [3:0] alu_dr;
    logic       alu_e;
    logic [3:0] alu_result;
    logic       alu_co;
    logic       alu_ovf;
    logic [3:0] ac;
    logic       e;
    logic       n_flag;
    logic       z_flag;
    logic       v_flag;

    int checks   = 0;
    int failures = 0;

    acc_exec_ctrl #(.W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .done(done), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_data(mem_data), .alu_op(alu_op), .alu_ac(alu_ac), .alu_dr(alu_dr),
        .alu_e(alu_e), .alu_result(alu_result), .alu_co(alu_co), .alu_ovf(alu_ovf),
        .ac(ac), .e(e), .n_flag(n_flag), .z_flag(z_flag), .v_flag(v_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Basic Computer ALU
    logic [4:0] sum5;
    always_comb begin
        sum5       = {1'b0, alu_ac} + {1'b0, alu_dr};
        alu_result = 4'h0;
        alu_co     = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_result = sum5[3:0];
                alu_co     = sum5[4];
                alu_ovf    = (alu_ac[3] == alu_dr[3]) && (sum5[3] != alu_ac[3]);
            end
            3'd1: alu_result = alu_ac & alu_dr;
            3'd2: alu_result = alu_dr;
            3'd3: alu_result = ~alu_ac;
            3'd4: begin alu_result = {alu_e, alu_ac[3:1]}; alu_co = alu_ac[0]; end
            3'd5: begin alu_result = {alu_ac[2:0], alu_e}; alu_co = alu_ac[3]; end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one command; ack arrives after dly extra FETCH cycles. Returns
    // accept-to-done latency, FETCH cycle count and the op seen in EXEC.
    task automatic do_cmd(input logic [2:0] c, input logic [3:0] d, input int dly,
                          input bit inj, output int lat, output int reqcnt,
                          output logic [2:0] exec_op);
        logic [2:0] prev_op;
        bit got;
        got = 0; lat = 0; reqcnt = 0; exec_op = 3'd7; prev_op = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1; lat = n; exec_op = prev_op;
            end else if (mem_req) begin
                reqcnt++;
                chk("cmd_ready_in_fetch", cmd_ready, 0);
                chk("alu_op_in_fetch", alu_op, 0);
                mem_ack  = (reqcnt > dly);
                mem_data = d;
                if (inj) begin cmd_valid = 1'b1; cmd = 3'd6; end
            end else begin
                mem_ack = 1'b0;
                cmd_valid = 1'b0;
            end
            prev_op = alu_op;
        end
        mem_ack = 1'b0;
        cmd_valid = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [2:0] c;
        logic [3:0] d;
        int         dly;
        bit         inj;
        logic [3:0] ac;
        logic       e, n, z, v;
        int         lat;
        logic [2:0] op;
    } vec_t;

    vec_t vecs[13];
    int lat, reqcnt;
    logic [2:0] eop;

    initial begin
        //             cmd   data  dly inj  ac    e  n  z  v  lat op
        vecs[0]  = '{3'd2, 4'h9, 0, 0, 4'h9, 0, 1, 0, 0, 3, 3'd2}; // LDA
        vecs[1]  = '{3'd0, 4'h8, 0, 0, 4'h1, 1, 0, 0, 1, 3, 3'd0}; // ADD
        vecs[2]  = '{3'd1, 4'h3, 1, 0, 4'h1, 1, 0, 0, 0, 4, 3'd1}; // AND
        vecs[3]  = '{3'd2, 4'hA, 0, 0, 4'hA, 1, 1, 0, 0, 3, 3'd2}; // LDA
        vecs[4]  = '{3'd5, 4'h0, 0, 0, 4'h5, 1, 0, 0, 0, 2, 3'd5}; // CIL
        vecs[5]  = '{3'd7, 4'h0, 0, 0, 4'h5, 0, 0, 0, 0, 2, 3'd0}; // CLE
        vecs[6]  = '{3'd4, 4'h0, 0, 0, 4'h2, 1, 0, 0, 0, 2, 3'd4}; // CIR
        vecs[7]  = '{3'd0, 4'hE, 3, 1, 4'h0, 1, 0, 1, 0, 6, 3'd0}; // ADD late ack
        vecs[8]  = '{3'd6, 4'h0, 0, 0, 4'h0, 1, 0, 1, 0, 2, 3'd0}; // CLA
        vecs[9]  = '{3'd3, 4'h0, 0, 0, 4'hF, 1, 1, 0, 0, 2, 3'd3}; // CMA
        vecs[10] = '{3'd0, 4'h1, 0, 0, 4'h0, 1, 0, 1, 0, 3, 3'd0}; // ADD wrap
        vecs[11] = '{3'd0, 4'h7, 0, 0, 4'h7, 0, 0, 0, 0, 3, 3'd0}; // ADD
        vecs[12] = '{3'd0, 4'h1, 0, 0, 4'h8, 0, 1, 0, 1, 3, 3'd0}; // ADD overflow

        reset = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; mem_ack = 1'b0; mem_data = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_ac", ac, 0);
        chk("rst_e", e, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_flags", {n_flag, z_flag, v_flag}, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].c, vecs[i].d, vecs[i].dly, vecs[i].inj, lat, reqcnt, eop);
            chk($sformatf("v%0d_ac", i), ac, vecs[i].ac);
            chk($sformatf("v%0d_e", i), e, vecs[i].e);
            chk($sformatf("v%0d_n", i), n_flag, vecs[i].n & FL);
            chk($sformatf("v%0d_z", i), z_flag, vecs[i].z & FL);
            chk($sformatf("v%0d_v", i), v_flag, vecs[i].v & FL);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_op", i), eop, vecs[i].op);
            chk($sformatf("v%0d_reqcycles", i), reqcnt, (vecs[i].c <= 3'd2) ? vecs[i].dly + 1 : 0);
            chk($sformatf("v%0d_ready_with_done", i), cmd_ready, 1);
            @(negedge clk);
            chk($sformatf("v%0d_done_single", i), done, 0);
        end

        // Reset asserted in the middle of FETCH
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mf_mem_req_before", mem_req, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mf_mem_req_async", mem_req, 0);
        chk("mf_ac", ac, 0);
        chk("mf_e", e, 0);
        chk("mf_done", done, 0);
        chk("mf_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_data = 4'h7;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("mf_late_ack_done", done, 0);
        end
        mem_ack = 1'b0;
        chk("mf_late_ack_dr", alu_dr, 0);
        chk("mf_late_ack_mem_req", mem_req, 0);
        chk("mf_late_ack_ac", ac, 0);

        // Stray ack in IDLE, then CMA from AC=0
        @(negedge clk);
        mem_ack = 1'b1; mem_data = 4'h5;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_dr", alu_dr, 0);
        do_cmd(3'd3, 4'h0, 0, 0, lat, reqcnt, eop);
        chk("cma_ac", ac, 4'hF);
        chk("cma_n", n_flag, FL);
        chk("cma_z", z_flag, 0);
        chk("cma_lat", lat, 2);
        chk("cma_op", eop, 3);
        chk("cma_dr", alu_dr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
